multicore_boot_arbiter: RTL and testbench

//  Per-core reset sequencer and output collector for an array of N rede_float-style cores that share one io_in bus.

---
 rtl/multicore_boot_arbiter.sv | 96 +++++++++
 tb/tb_multicore_boot_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/multicore_boot_arbiter.sv
// multicore_boot_arbiter: staggered per-core reset release plus round-robin collection of core output pulses into a FIFO
module multicore_boot_arbiter #(
  parameter int N_CORES = 51,
  parameter int DATA_W = 28,
  parameter int EN_W = 4,
  parameter int STAGGER = 6,
  parameter int FIFO_DEPTH = 4,
  localparam int TAG_W = $clog2(N_CORES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CORES*DATA_W-1:0] core_io_out,
  input  logic [N_CORES*EN_W-1:0]   core_out_en,
  output logic [N_CORES-1:0]        core_rst,
  output logic                      boot_done,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [EN_W-1:0]           out_en,
  output logic [TAG_W-1:0]          out_tag,
  output logic [N_CORES-1:0]        overflow
);
  localparam int IDX_W = $clog2(N_CORES + 1);
  localparam int CNT_W = $clog2(STAGGER + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int W = EN_W + DATA_W;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [N_CORES-1:0] pend, req, gnt;
  logic [W-1:0] slot [N_CORES];
  logic [TAG_W+W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wp, rp;
  logic [PW:0] count;
  logic [TAG_W-1:0] ptr, gidx, j;
  logic found, gv, pop;
  assign out_valid = count != '0;
  assign pop = out_valid & out_ready;
  assign {out_tag, out_en, out_data} = out_valid ? mem[rp] : '0;
  always_comb begin
    req = '0;
    for (int k = 0; k < N_CORES; k++)
      req[k] = |core_out_en[k*EN_W +: EN_W] && !core_rst[k];
  end
  // first pending slot at or after ptr, wrapping
  always_comb begin
    found = 1'b0;
    gidx = '0;
    j = '0;
    for (int i = 0; i < N_CORES; i++) begin
      j = TAG_W'((int'(ptr) + i) % N_CORES);
      if (!found && pend[j]) begin
        found = 1'b1;
        gidx = j;
      end
    end
    gv = found && (count != (PW+1)'(FIFO_DEPTH) || pop);
    gnt = gv ? N_CORES'(1) << gidx : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      core_rst <= '1;
      boot_done <= 1'b0;
      idx <= '0;
      cnt <= '0;
      pend <= '0;
      overflow <= '0;
      ptr <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (!boot_done) begin
        if (int'(idx) == N_CORES) boot_done <= 1'b1;
        else if (cnt == '0) begin
          core_rst[TAG_W'(idx)] <= 1'b0;
          idx <= idx + 1'b1;
          cnt <= CNT_W'(STAGGER - 1);
        end else cnt <= cnt - 1'b1;
      end
      // a slot granted this cycle is free to take a new word at the same edge
      for (int k = 0; k < N_CORES; k++) begin
        if (req[k] && pend[k] && !gnt[k]) overflow[k] <= 1'b1;
        if (req[k] && (!pend[k] || gnt[k]))
          slot[k] <= {core_out_en[k*EN_W +: EN_W], core_io_out[k*DATA_W +: DATA_W]};
      end
      pend <= req | (pend & ~gnt);
      if (gv) begin
        mem[wp] <= {gidx, slot[gidx]};
        wp <= wp + 1'b1;
        ptr <= gidx == TAG_W'(N_CORES - 1) ? '0 : gidx + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + {{PW{1'b0}}, gv} - {{PW{1'b0}}, pop};
    end
  end
endmodule

// File: tb/tb_multicore_boot_arbiter.sv
// tb_multicore_boot_arbiter: vector table plus hand sequences, scoreboard of expected tagged words
module tb_multicore_boot_arbiter;
  localparam int N = 4, DW = 28, EW = 4, S = 6, D = 4, TW = 2;
  logic clk = 1'b0, rst = 1'b1, out_ready = 1'b1;
  logic [N*DW-1:0] io = '0;
  logic [N*EW-1:0] en = '0;
  logic [N-1:0] core_rst, overflow;
  logic boot_done, out_valid;
  logic [DW-1:0] out_data;
  logic [EW-1:0] out_en;
  logic [TW-1:0] out_tag;
  int checks = 0, errors = 0;
  typedef struct packed {logic [TW-1:0] tag; logic [EW-1:0] e; logic [DW-1:0] d;} item_t;
  typedef struct {logic [N-1:0] mask; logic [N*DW-1:0] d; logic [N*EW-1:0] e; logic [N*TW-1:0] ord; int n;} vec_t;
  item_t sb[$];
  item_t x;
  vec_t vt[5];
  int t;

  multicore_boot_arbiter #(.N_CORES(N), .DATA_W(DW), .EN_W(EW), .STAGGER(S), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .core_io_out(io), .core_out_en(en), .core_rst(core_rst),
    .boot_done(boot_done), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_en(out_en), .out_tag(out_tag), .overflow(overflow));

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask

  task automatic pop_chk(input string nm);
    item_t y;
    chk({nm, " valid"}, out_valid, 1);
    if (sb.size() == 0) chk({nm, " sb underflow"}, 1, 0);
    else begin
      y = sb.pop_front();
      chk({nm, " tag"}, out_tag, y.tag);
      chk({nm, " en"}, out_en, y.e);
      chk({nm, " data"}, out_data, y.d);
    end
  endtask

  task automatic boot();
    logic [N-1:0] exp_rst;
    rst = 1'b1;
    en = '0;
    tick;
    chk("rst core_rst", core_rst, 4'hF);
    chk("rst boot_done", boot_done, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst overflow", overflow, 0);
    chk("rst out word", {out_tag, out_en, out_data}, 0);
    rst = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      tick;
      for (int k = 0; k < N; k++) exp_rst[k] = !(c >= 1 + S*k);
      chk($sformatf("boot c%0d core_rst", c), core_rst, exp_rst);
      chk($sformatf("boot c%0d boot_done", c), boot_done, c >= 20);
      chk($sformatf("boot c%0d out_valid", c), out_valid, 0);
      if (c == 3) begin
        en[1*EW +: EW] = 4'd1;
        io[1*DW +: DW] = DW'(77);
      end
      if (c == 4) en = '0;
    end
    chk("boot overflow", overflow, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vt[0] = '{4'b1101, {DW'(7), DW'(-5), DW'(0), DW'(100)}, {4'd1, 4'd1, 4'd1, 4'd1}, {2'd0, 2'd3, 2'd2, 2'd0}, 3};
    vt[1] = '{4'b0110, {DW'(0), DW'(28'h8000000), DW'(28'h7FFFFFF), DW'(0)}, {4'd0, 4'h8, 4'hF, 4'd0}, {2'd0, 2'd0, 2'd2, 2'd1}, 2};
    vt[2] = '{4'b1111, {DW'(123456), DW'(-100), DW'(1), DW'(-1)}, {4'd5, 4'd4, 4'd3, 4'd2}, {2'd2, 2'd1, 2'd0, 2'd3}, 4};
    vt[3] = '{4'b0001, {DW'(0), DW'(0), DW'(0), DW'(-12345)}, {4'd0, 4'd0, 4'd0, 4'hA}, {2'd0, 2'd0, 2'd0, 2'd0}, 1};
    vt[4] = '{4'b1010, {DW'(-55), DW'(0), DW'(55), DW'(0)}, {4'd9, 4'd0, 4'd6, 4'd0}, {2'd0, 2'd0, 2'd3, 2'd1}, 2};
    boot();
    for (int v = 0; v < 5; v++) begin
      for (int k = 0; k < N; k++) en[k*EW +: EW] = vt[v].mask[k] ? vt[v].e[k*EW +: EW] : '0;
      io = vt[v].d;
      for (int j = 0; j < vt[v].n; j++) begin
        t = int'(vt[v].ord[j*TW +: TW]);
        sb.push_back('{TW'(t), vt[v].e[t*EW +: EW], vt[v].d[t*DW +: DW]});
      end
      tick;
      en = '0;
      tick;
      for (int j = 0; j < vt[v].n; j++) begin
        pop_chk($sformatf("vec%0d w%0d", v, j));
        tick;
      end
      chk($sformatf("vec%0d idle", v), out_valid, 0);
    end
    // FIFO fills with ready low, second pulses park in pending, third pulses overflow
    out_ready = 1'b0;
    for (int k = 0; k < N; k++) begin
      en[k*EW +: EW] = EW'(k + 1);
      io[k*DW +: DW] = DW'(1000 + k);
      sb.push_back('{TW'(k), EW'(k + 1), DW'(1000 + k)});
    end
    tick;
    en = '0;
    for (int c = 0; c < 4; c++) begin
      tick;
      chk($sformatf("hold%0d valid", c), out_valid, 1);
      chk($sformatf("hold%0d head", c), {out_tag, out_data}, {2'd0, DW'(1000)});
    end
    for (int k = 0; k < N; k++) begin
      en[k*EW +: EW] = 4'd8;
      io[k*DW +: DW] = DW'(-2000 - k);
      sb.push_back('{TW'(k), 4'd8, DW'(-2000 - k)});
    end
    tick;
    en = '0;
    chk("second pulse overflow", overflow, 0);
    en[1*EW +: EW] = 4'd3;
    en[3*EW +: EW] = 4'd3;
    io[1*DW +: DW] = DW'(3001);
    io[3*DW +: DW] = DW'(3003);
    tick;
    en = '0;
    chk("third pulse overflow", overflow, 4'b1010);
    tick;
    chk("full head stable", {out_valid, out_tag, out_en, out_data}, {1'b1, 2'd0, 4'd1, DW'(1000)});
    chk("overflow sticky", overflow, 4'b1010);
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      pop_chk($sformatf("full drain w%0d", j));
      tick;
    end
    chk("full drain idle", out_valid, 0);
    chk("full drain sb empty", sb.size(), 0);
    // reset with three words queued
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      en[k*EW +: EW] = 4'd1;
      io[k*DW +: DW] = DW'(4000 + k);
    end
    tick;
    en = '0;
    tick;
    tick;
    tick;
    chk("three queued valid", out_valid, 1);
    chk("three queued head", out_data, DW'(4000));
    sb.delete();
    boot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
